dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single-port data memory (DRAM, combinational read `spo`, write on clock edge) between two requesters.
- Requester 0 is the CPU core data port. Requester 1 is a memory loader/debug port that preloads or inspects DRAM.
- Round-robin arbitration, one access in flight at a time, registered read data, explicit acknowledge per transfer.
- Sits between the core/loader and the DRAM instance inside the SoC top.

Parameters:
- ADDR_W, 16, DRAM address width driven on `dram_a` (taken from `mN_addr[ADDR_W-1:0]`).
- DATA_W, 32, data width of all read/write buses.

Ports:
- fpga_clk  input  1  system clock; all state updates on rising edge.
- fpga_rst  input  1  synchronous, active-high reset.
- m0_req  input  1  CPU request; held high until `m0_ack`.
- m0_we  input  1  CPU write enable (1 = write, 0 = read).
- m0_addr  input  32  CPU byte address.
- m0_wdata  input  DATA_W  CPU write data.
- m0_ack  output  1  one-cycle pulse: CPU transfer complete.
- m0_rdata  output  DATA_W  CPU read data; valid in the `m0_ack` cycle.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0, for the loader port.
- dram_a  output  ADDR_W  DRAM address.
- dram_we  output  1  DRAM write enable.
- dram_d  output  DATA_W  DRAM write data.
- dram_spo  input  DATA_W  DRAM combinational read data.
- busy  output  1  high whenever state != IDLE.
- grant  output  1  requester currently owning the access (0/1); valid when busy.

Behaviour:
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req is high, select a winner and latch its we/addr/wdata into internal registers, set `grant`, then go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration (round-robin):
  - `last` register, reset 1, so m0 wins the first contested cycle.
  - If only one req is high, that requester wins.
  - If both are high, the requester != `last` wins.
- ACCESS (exactly 1 cycle):
  - `dram_a` = latched addr[ADDR_W-1:0]; `dram_d` = latched wdata; `dram_we` = latched we.
  - `dram_spo` is captured into the rdata register at the end of the cycle.
- RESP (1 cycle):
  - Assert `ack` of the granted requester only.
  - Its `rdata` carries the captured value for reads; for writes it carries the old memory word (don't-care to the requester).
  - `last` <= grant; go to IDLE.
- Latency and throughput:
  - req sampled in IDLE at cycle t -> DRAM access at t+1 -> ack at t+2.
  - Maximum rate is one transfer per 3 cycles.
  - A req still high in the IDLE cycle after ack is treated as a new request.
- Outside ACCESS: `dram_we` = 0; `dram_a`/`dram_d` hold the latched values.
- `mN_rdata` holds its last value between acks; both are reset to 0.
- Requester rules: addr/we/wdata must be stable from req rise to ack. A req dropped before ack is a protocol violation; the latched transfer still completes and acks.
- Reset values: state IDLE, `last`=1, `grant`=0, `busy`=0, both acks 0, both rdata 0, latched regs 0, `dram_we`=0.
- `fpga_rst` asserted in any state returns the FSM to IDLE on the next edge, with no ack.
- `dram_we` is gated with `!fpga_rst`, so a write in ACCESS coinciding with reset is suppressed.
- Both reqs rising in the same cycle: resolved by the round-robin rule above; no request is lost, and the loser is served in the next IDLE.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: m0 always wins contested IDLE cycles; `last` is unused. m1 may starve while the CPU holds req continuously.
- Undefined: round-robin as specified.

Decomposition:
- Shared package `dram_arb_pkg`:
  - state enum: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - constants: ARB_M0=1'b0, ARB_M1=1'b1.
  - defaults for ADDR_W/DATA_W.
- One natural sub-module, `rr_arb2`: combinational 2-way round-robin select with inputs req[1:0], last, and the fixed-priority macro; output winner.
- FSM, latches and output muxing remain in `dram_arbiter`.

Test Plan:
- m0 write addr 0x0000_0010 data 0xDEAD_BEEF, then m0 read of the same addr:
  - `dram_we`=1 for exactly one cycle with `dram_a`=0x0010.
  - write ack at t+2; read ack returns `m0_rdata`=0xDEAD_BEEF.
- Both reqs held continuously, reads of distinct preloaded words:
  - ack order m0, m1, m0, m1.
  - each ack 3 cycles apart; each rdata matches its own address.
- With ARB_FIXED_PRIO_EN defined and the same stimulus:
  - only `m0_ack` pulses; `m1_ack` never pulses while `m0_req`=1.
- m1 write 0x1234_5678 to 0x0020 with `fpga_rst` asserted during the ACCESS cycle:
  - `dram_we` stays 0 and no ack is issued.
  - after reset, a read of 0x0020 returns the prior contents.
- Reset values: all outputs match the reset list (`busy`=0, acks=0, rdata=0) during and one cycle after reset.
- m0_req and m1_req rise in the same cycle right after reset:
  - m0 granted first (`grant`=0); m1 acked 3 cycles later with `grant`=1.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-requester DRAM arbiter.
// Optional build macro: ARB_FIXED_PRIO_EN (m0 always wins contested cycles).
package dram_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// Combinational 2-way arbiter. Round-robin on `last` by default;
// with ARB_FIXED_PRIO_EN defined, m0 always wins and `last` is ignored.
module rr_arb2
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last_s;
    assign unused_last_s = last;

    // Fixed priority: m0 first, m1 only when m0 is idle.
    always_comb begin
        winner = ARB_M0;
        if (req[0]) begin
            winner = ARB_M0;
        end else if (req[1]) begin
            winner = ARB_M1;
        end else begin
            winner = ARB_M0;
        end
    end
`else
    // Round-robin: a contested cycle goes to the requester not served last.
    always_comb begin
        winner = ARB_M0;
        case (req)
            2'b01:   winner = ARB_M0;
            2'b10:   winner = ARB_M1;
            2'b11:   winner = (last == ARB_M0) ? ARB_M1 : ARB_M0;
            default: winner = ARB_M0;
        endcase
    end
`endif

endmodule

// File: rtl/dram_arbiter.sv
// Shares a single-port DRAM (combinational read, clocked write) between the
// CPU data port (m0) and the loader/debug port (m1). One transfer in flight:
// IDLE (arbitrate + latch) -> ACCESS (drive DRAM, capture spo) -> RESP (ack).
// Optional build macro: ARB_FIXED_PRIO_EN (see rr_arb2).
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              fpga_clk,
    input  logic              fpga_rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] dram_a,
    output logic              dram_we,
    output logic [DATA_W-1:0] dram_d,
    input  logic [DATA_W-1:0] dram_spo,

    output logic              busy,
    output logic              grant
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              winner_s;

    // Only the low ADDR_W byte-address bits reach the DRAM.
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^{m0_addr[31:ADDR_W], m1_addr[31:ADDR_W]};

    rr_arb2 u_arb (
        .req    ({m1_req, m0_req}),
        .last   (last_q),
        .winner (winner_s)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            state_q    <= IDLE;
            last_q     <= ARB_M1;
            grant_q    <= ARB_M0;
            we_q       <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= {DATA_W{1'b0}};
            m1_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Next-state: leave IDLE on any request, then ACCESS and RESP for one cycle each.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state register updates: latch winner in IDLE, capture spo and raise
    // the ack at the end of ACCESS, record the served requester in RESP.
    always_comb begin
        last_d     = last_q;
        grant_d    = grant_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d = winner_s;
                    if (winner_s == ARB_M1) begin
                        we_d    = m1_we;
                        addr_d  = m1_addr[ADDR_W-1:0];
                        wdata_d = m1_wdata;
                    end else begin
                        we_d    = m0_we;
                        addr_d  = m0_addr[ADDR_W-1:0];
                        wdata_d = m0_wdata;
                    end
                end else begin
                    grant_d = grant_q;
                end
            end
            ACCESS: begin
                if (grant_q == ARB_M1) begin
                    m1_ack_d   = 1'b1;
                    m1_rdata_d = dram_spo;
                end else begin
                    m0_ack_d   = 1'b1;
                    m0_rdata_d = dram_spo;
                end
            end
            RESP: begin
                last_d = grant_q;
            end
            default: begin
                last_d = last_q;
            end
        endcase
    end

    // DRAM write strobe only in ACCESS, and never while reset is asserted.
    assign dram_we  = (state_q == ACCESS) && we_q && !fpga_rst;
    assign dram_a   = addr_q;
    assign dram_d   = wdata_q;

    assign busy     = (state_q != IDLE);
    assign grant    = grant_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: a transaction-timeline model plus a
// behavioural DRAM, a per-cycle compare process and directed scenarios.
module tb_dram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          fpga_clk = 1'b0;
    logic          fpga_rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0]   m0_addr = 32'd0;
    logic [DW-1:0] m0_wdata = 32'd0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0]   m1_addr = 32'd0;
    logic [DW-1:0] m1_wdata = 32'd0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] dram_a;
    logic          dram_we;
    logic [DW-1:0] dram_d;
    logic [DW-1:0] dram_spo;
    logic          busy;
    logic          grant;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    always #5 fpga_clk = ~fpga_clk;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .fpga_clk (fpga_clk), .fpga_rst (fpga_rst),
        .m0_req   (m0_req),   .m0_we    (m0_we),    .m0_addr (m0_addr),
        .m0_wdata (m0_wdata), .m0_ack   (m0_ack),   .m0_rdata (m0_rdata),
        .m1_req   (m1_req),   .m1_we    (m1_we),    .m1_addr (m1_addr),
        .m1_wdata (m1_wdata), .m1_ack   (m1_ack),   .m1_rdata (m1_rdata),
        .dram_a   (dram_a),   .dram_we  (dram_we),  .dram_d  (dram_d),
        .dram_spo (dram_spo), .busy     (busy),     .grant   (grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural DRAM: word at a = {16'hA5A5, a} until written.
    logic [31:0] mem [0:65535];
    bit mem_ready = 1'b0;
    assign dram_spo = mem[dram_a];
    always @(posedge fpga_clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= {16'hA5A5, i[15:0]};
            mem_ready <= 1'b1;
        end else if (dram_we) begin
            mem[dram_a] <= dram_d;
        end
    end

    // Reference model: a transfer sampled in cycle t0 accesses memory in t0+1,
    // acks in t0+2, and the arbiter may accept again from t0+3.
    logic [31:0] ref_mem [0:65535];
    bit          ref_ready = 1'b0;
    bit          m_have = 1'b0;
    int          m_t0 = 0;
    logic        m_who = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
    logic        m_last = 1'b1, m_grant = 1'b0;
    logic [31:0] m_rd0 = 32'd0, m_rd1 = 32'd0;

    always @(posedge fpga_clk) begin : model_p
        int ph;
        logic [31:0] old;
        logic w;
        if (!ref_ready) begin
            for (int i = 0; i < 65536; i++) ref_mem[i] = {16'hA5A5, i[15:0]};
            ref_ready = 1'b1;
        end
        if (fpga_rst) begin
            m_have = 1'b0; m_last = 1'b1; m_grant = 1'b0;
            m_rd0 = 32'd0; m_rd1 = 32'd0;
        end else begin
            ph = cyc - m_t0;
            if (m_have && ph == 1) begin
                old = ref_mem[m_addr[15:0]];
                if (m_we) ref_mem[m_addr[15:0]] = m_wdata;
                if (m_who) m_rd1 = old;
                else       m_rd0 = old;
            end
            if (m_have && ph == 2) m_last = m_who;
            if ((!m_have || ph >= 3) && (m0_req || m1_req)) begin
                if (m0_req && m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
                    w = 1'b0;
`else
                    w = !m_last;
`endif
                end else begin
                    w = m1_req;
                end
                m_have = 1'b1; m_t0 = cyc; m_who = w; m_grant = w;
                m_we    = w ? m1_we    : m0_we;
                m_addr  = w ? m1_addr  : m0_addr;
                m_wdata = w ? m1_wdata : m0_wdata;
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge fpga_clk) begin : compare_p
        int ph;
        bit acc, rsp;
        if (cmp_en) begin
            ph  = cyc - m_t0;
            acc = m_have && (ph == 1);
            rsp = m_have && (ph == 2);
            check("busy",     32'(busy),    32'(acc || rsp));
            check("grant",    32'(grant),   32'(m_grant));
            check("m0_ack",   32'(m0_ack),  32'(rsp && !m_who));
            check("m1_ack",   32'(m1_ack),  32'(rsp && m_who));
            check("m0_rdata", m0_rdata,     m_rd0);
            check("m1_rdata", m1_rdata,     m_rd1);
            check("dram_we",  32'(dram_we), 32'(acc && m_we && !fpga_rst));
            if (acc) begin
                check("dram_a", 32'(dram_a), {16'h0000, m_addr[15:0]});
                check("dram_d", dram_d,      m_wdata);
            end
        end
    end

    // Ack / write-strobe log for the directed checks.
    int          ack_who[$];
    int          ack_cyc[$];
    logic [31:0] ack_data[$];
    logic        ack_grant[$];
    int          we_cnt = 0;
    logic [15:0] we_a = 16'h0000;
    always @(negedge fpga_clk) begin
        if (m0_ack === 1'b1) begin
            ack_who.push_back(0); ack_cyc.push_back(cyc);
            ack_data.push_back(m0_rdata); ack_grant.push_back(grant);
        end
        if (m1_ack === 1'b1) begin
            ack_who.push_back(1); ack_cyc.push_back(cyc);
            ack_data.push_back(m1_rdata); ack_grant.push_back(grant);
        end
        if (dram_we === 1'b1) begin
            we_cnt++;
            we_a = dram_a;
        end
    end

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        fpga_rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        repeat (n) tick();
        fpga_rst = 1'b0;
    endtask

    task automatic single(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rd);
        int  t_start;
        bit  seen;
        if (port) begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end else begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end
        t_start = cyc;
        seen = 1'b0;
        lat = -1;
        rd = 32'd0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge fpga_clk);
            if ((port ? m1_ack : m0_ack) === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t_start;
                rd   = port ? m1_rdata : m0_rdata;
            end
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
        tick();
        if (port) m1_req = 1'b0;
        else      m0_req = 1'b0;
    endtask

    task automatic reset_literals(input string tag);
        check({tag, "_busy"},   32'(busy),    32'd0);
        check({tag, "_grant"},  32'(grant),   32'd0);
        check({tag, "_m0_ack"}, 32'(m0_ack),  32'd0);
        check({tag, "_m1_ack"}, 32'(m1_ack),  32'd0);
        check({tag, "_m0_rd"},  m0_rdata,     32'd0);
        check({tag, "_m1_rd"},  m1_rdata,     32'd0);
        check({tag, "_we"},     32'(dram_we), 32'd0);
    endtask

    initial begin : watchdog_p
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : main_p
        int          lat;
        logic [31:0] rd;
        int          base_we, base_ack, t_start, k;
        bit          exp_who;

        // Reset values during and one cycle after reset.
        tick();
        cmp_en = 1'b1;
        reset_literals("rst_during");
        tick();
        fpga_rst = 1'b0;
        tick();
        reset_literals("rst_after");

        // m0 write 0xDEADBEEF to 0x10, then read it back.
        base_we = we_cnt;
        single(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd);
        check("wr_latency",  32'(lat),            32'd2);
        check("wr_we_count", 32'(we_cnt - base_we), 32'd1);
        check("wr_dram_a",   32'(we_a),           32'h0000_0010);
        single(1'b0, 1'b0, 32'h0000_0010, 32'd0, lat, rd);
        check("rd_latency",  32'(lat),            32'd2);
        check("rd_data",     rd,                  32'hDEAD_BEEF);

        // m1 write aborted by reset during ACCESS.
        base_we  = we_cnt;
        base_ack = ack_who.size();
        m1_we = 1'b1; m1_addr = 32'h0000_0020; m1_wdata = 32'h1234_5678; m1_req = 1'b1;
        tick();
        check("abort_in_access", 32'(busy), 32'd1);
        fpga_rst = 1'b1; m1_req = 1'b0; m1_we = 1'b0;
        tick();
        tick();
        fpga_rst = 1'b0;
        tick();
        tick();
        check("abort_we_count",  32'(we_cnt - base_we),             32'd0);
        check("abort_ack_count", 32'(ack_who.size() - base_ack),    32'd0);
        single(1'b1, 1'b0, 32'h0000_0020, 32'd0, lat, rd);
        check("abort_readback",  rd, 32'hA5A5_0020);

        // Both requesters held continuously, reading distinct words.
        do_reset(2);
        tick();
        ack_who.delete(); ack_cyc.delete(); ack_data.delete(); ack_grant.delete();
        m0_we = 1'b0; m0_addr = 32'h0000_0100;
        m1_we = 1'b0; m1_addr = 32'h0000_0200;
        m0_req = 1'b1; m1_req = 1'b1;
        t_start = cyc;
        for (k = 0; k < 60 && ack_who.size() < 4; k++) begin
            @(negedge fpga_clk);
            #1;
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        if (ack_who.size() < 4) begin
            check("rr_ack_timeout", 32'(ack_who.size()), 32'd4);
        end else begin
            check("rr_first_latency", 32'(ack_cyc[0] - t_start), 32'd2);
            for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
                exp_who = 1'b0;
`else
                exp_who = (i % 2 == 1);
`endif
                check("rr_who",   32'(ack_who[i]),   32'(exp_who));
                check("rr_grant", 32'(ack_grant[i]), 32'(exp_who));
                check("rr_data",  ack_data[i], exp_who ? 32'hA5A5_0200 : 32'hA5A5_0100);
                if (i > 0) check("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
            end
        end
        tick();
        tick();

        // Simultaneous rise right after reset: m0 first, m1 three cycles later.
        do_reset(2);
        ack_who.delete(); ack_cyc.delete(); ack_data.delete(); ack_grant.delete();
        m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
        m0_req = 1'b1; m1_req = 1'b1;
        for (k = 0; k < 20 && ack_who.size() < 1; k++) begin
            @(negedge fpga_clk);
            #1;
        end
        tick();
        m0_req = 1'b0;
        for (k = 0; k < 20 && ack_who.size() < 2; k++) begin
            @(negedge fpga_clk);
            #1;
        end
        tick();
        m1_req = 1'b0;
        if (ack_who.size() < 2) begin
            check("sim_ack_timeout", 32'(ack_who.size()), 32'd2);
        end else begin
            check("sim_first_who",   32'(ack_who[0]),   32'd0);
            check("sim_first_grant", 32'(ack_grant[0]), 32'd0);
            check("sim_second_who",  32'(ack_who[1]),   32'd1);
            check("sim_second_grant",32'(ack_grant[1]), 32'd1);
            check("sim_spacing",     32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
            check("sim_m1_data",     ack_data[1], 32'hA5A5_0200);
        end
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
